// File: rtl/dmd_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmd_video_pkg
// Summary  : Shared constants, pipeline flag bundle and width helper for the
//            DMD panel video generator.
// Revision : 1.0
// ============================================================================
package dmd_video_pkg;

    localparam logic [1:0] BM_NONE  = 2'd0;
    localparam logic [1:0] BM_BLACK = 2'd1;
    localparam logic [1:0] BM_DIM   = 2'd2;

    // Per-pixel attributes carried alongside the pixel-store fetch
    typedef struct packed {
        logic [1:0] mode;
        logic       draw;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       gap;
        logic       oob;
    } pipe_flags_t;

    // Never returns 0, so a one-entry range still gets a 1-bit vector
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : dmd_video_pkg
`default_nettype wire

// File: rtl/dmd_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : dmd_delay_line
// Summary  : WIDTH x DEPTH register shift line with asynchronous active-low
//            clear.
// Revision : 1.0
// ============================================================================
module dmd_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign dout = r_stage[DEPTH-1];

endmodule : dmd_delay_line
`default_nettype wire

// File: rtl/dmd_video_gen.sv
`default_nettype none
// ============================================================================
// Module   : dmd_video_gen
// Summary  : Raster timing and DOT x DOT dot-matrix upscaler; issues pixel
//            store addresses and aligns returned colour with the strobes.
// Revision : 1.0
// ============================================================================
module dmd_video_gen
    import dmd_video_pkg::*;
#(
    parameter int H_DRAW    = 1280,
    parameter int H_PORCH   = 32,
    parameter int H_SYNC    = 96,
    parameter int H_FRAME   = 1440,
    parameter int V_DRAW    = 390,
    parameter int V_PORCH   = 1,
    parameter int V_SYNC    = 24,
    parameter int V_FRAME   = 442,
    parameter int DOT       = 10,
    parameter int GAP       = 1,
    parameter int DOTS_X    = 128,
    parameter int DOTS_Y    = 39,
    parameter int FETCH_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                border_mode,
    output logic [clog2w(DOTS_X)-1:0] dot_x,
    output logic [clog2w(DOTS_Y)-1:0] dot_y,
    input  logic [7:0]                dot_r,
    input  logic [7:0]                dot_g,
    input  logic [7:0]                dot_b,
    output logic                      draw_area,
    output logic                      h_sync,
    output logic                      v_sync,
    output logic                      frame_start,
    output logic [7:0]                red,
    output logic [7:0]                green,
    output logic [7:0]                blue
);

    localparam int c_cx_w = clog2w(H_FRAME);
    localparam int c_cy_w = clog2w(V_FRAME);
    localparam int c_s_w  = clog2w(DOT);
    localparam int c_dc_w = clog2w(H_FRAME / DOT + 1);
    localparam int c_dr_w = clog2w(V_FRAME / DOT + 1);
    localparam int c_x_w  = clog2w(DOTS_X);
    localparam int c_y_w  = clog2w(DOTS_Y);

    logic [c_cx_w-1:0] r_cx;
    logic [c_cy_w-1:0] r_cy;
    logic [c_s_w-1:0]  r_sx;
    logic [c_s_w-1:0]  r_sy;
    logic [c_dc_w-1:0] r_dc;
    logic [c_dr_w-1:0] r_dr;
    logic [1:0]        r_mode;
    logic [c_x_w-1:0]  r_dot_x;
    logic [c_y_w-1:0]  r_dot_y;
    pipe_flags_t       r_flags;

    logic        w_cx_last;
    logic        w_cy_last;
    logic        w_sx_last;
    logic        w_sy_last;
    pipe_flags_t w_flags;
    pipe_flags_t w_al;

    assign w_cx_last = (r_cx == c_cx_w'(H_FRAME - 1));
    assign w_cy_last = (r_cy == c_cy_w'(V_FRAME - 1));
    assign w_sx_last = (r_sx == c_s_w'(DOT - 1));
    assign w_sy_last = (r_sy == c_s_w'(DOT - 1));

    // Sub-dot and dot counters restart with the raster so no phase carries over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx <= '0;
            r_cy <= '0;
            r_sx <= '0;
            r_sy <= '0;
            r_dc <= '0;
            r_dr <= '0;
        end else if (w_cx_last) begin
            r_cx <= '0;
            r_sx <= '0;
            r_dc <= '0;
            if (w_cy_last) begin
                r_cy <= '0;
                r_sy <= '0;
                r_dr <= '0;
            end else begin
                r_cy <= r_cy + 1'b1;
                if (w_sy_last) begin
                    r_sy <= '0;
                    r_dr <= r_dr + 1'b1;
                end else begin
                    r_sy <= r_sy + 1'b1;
                end
            end
        end else begin
            r_cx <= r_cx + 1'b1;
            if (w_sx_last) begin
                r_sx <= '0;
                r_dc <= r_dc + 1'b1;
            end else begin
                r_sx <= r_sx + 1'b1;
            end
        end
    end

    // Border style only changes across a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= BM_BLACK;
        end else if (w_cx_last && w_cy_last) begin
            r_mode <= border_mode;
        end
    end

    always_comb begin
        w_flags      = '0;
        w_flags.mode = r_mode;
        w_flags.draw = (int'(r_cx) < H_DRAW) && (int'(r_cy) < V_DRAW);
        w_flags.hs   = (int'(r_cx) >= H_DRAW + H_PORCH) &&
                       (int'(r_cx) <  H_DRAW + H_PORCH + H_SYNC);
        w_flags.vs   = (int'(r_cy) >= V_DRAW + V_PORCH) &&
                       (int'(r_cy) <  V_DRAW + V_PORCH + V_SYNC);
        w_flags.fs   = (r_cx == '0) && (r_cy == '0);
        w_flags.gap  = (int'(r_sx) < GAP) || (int'(r_sx) >= DOT - GAP) ||
                       (int'(r_sy) < GAP) || (int'(r_sy) >= DOT - GAP);
        w_flags.oob  = (int'(r_dc) >= DOTS_X) || (int'(r_dr) >= DOTS_Y);
    end

    // Address and flags register together, then flags wait out the fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dot_x <= '0;
            r_dot_y <= '0;
            r_flags <= '0;
        end else begin
            r_dot_x <= (int'(r_dc) >= DOTS_X) ? c_x_w'(DOTS_X - 1) : c_x_w'(r_dc);
            r_dot_y <= (int'(r_dr) >= DOTS_Y) ? c_y_w'(DOTS_Y - 1) : c_y_w'(r_dr);
            r_flags <= w_flags;
        end
    end

    assign dot_x = r_dot_x;
    assign dot_y = r_dot_y;

    dmd_delay_line #(
        .WIDTH ($bits(pipe_flags_t)),
        .DEPTH (FETCH_LAT)
    ) u_flag_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (r_flags),
        .dout  (w_al)
    );

    assign draw_area   = w_al.draw;
    assign h_sync      = w_al.hs;
    assign v_sync      = w_al.vs;
    assign frame_start = w_al.fs;

    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        if (w_al.draw && !w_al.oob) begin
            if (!w_al.gap || (w_al.mode == BM_NONE)) begin
                red   = dot_r;
                green = dot_g;
                blue  = dot_b;
            end else if (w_al.mode == BM_DIM) begin
                red   = dot_r >> 2;
                green = dot_g >> 2;
                blue  = dot_b >> 2;
            end
        end
    end

endmodule : dmd_video_gen
`default_nettype wire

// File: tb/tb_dmd_video_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmd_video_gen
// Summary  : Directed self-checking bench for dmd_video_gen at default, narrow
//            grid, small raster and long fetch latency configurations.
// Revision : 1.0
// ============================================================================
module tb_dmd_video_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] border_mode = 2'd1;
    logic       store_const = 1'b0;
    int         cyc = 0;
    int         checks_total = 0;
    int         checks_passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [23:0] store_word(input logic [7:0] x, input logic [7:0] y);
        return store_const ? 24'hFFFFFF : {x, y, 8'hAA};
    endfunction

    // A: default parameters
    logic [6:0]  a_dot_x;
    logic [5:0]  a_dot_y;
    logic [7:0]  a_r, a_g, a_b;
    logic        a_draw, a_hs, a_vs, a_fs;
    logic [23:0] a_st [2];
    always @(posedge clk) begin
        a_st[0] <= store_word(8'(a_dot_x), 8'(a_dot_y));
        a_st[1] <= a_st[0];
    end
    dmd_video_gen u_a (
        .clk(clk), .rst_n(rst_n), .border_mode(border_mode),
        .dot_x(a_dot_x), .dot_y(a_dot_y),
        .dot_r(a_st[1][23:16]), .dot_g(a_st[1][15:8]), .dot_b(a_st[1][7:0]),
        .draw_area(a_draw), .h_sync(a_hs), .v_sync(a_vs), .frame_start(a_fs),
        .red(a_r), .green(a_g), .blue(a_b)
    );

    // B: 100-dot-wide grid
    logic [6:0]  b_dot_x;
    logic [5:0]  b_dot_y;
    logic [7:0]  b_r, b_g, b_b;
    logic        b_draw, b_hs, b_vs, b_fs;
    logic [23:0] b_st [2];
    always @(posedge clk) begin
        b_st[0] <= store_word(8'(b_dot_x), 8'(b_dot_y));
        b_st[1] <= b_st[0];
    end
    dmd_video_gen #(.DOTS_X(100)) u_b (
        .clk(clk), .rst_n(rst_n), .border_mode(border_mode),
        .dot_x(b_dot_x), .dot_y(b_dot_y),
        .dot_r(b_st[1][23:16]), .dot_g(b_st[1][15:8]), .dot_b(b_st[1][7:0]),
        .draw_area(b_draw), .h_sync(b_hs), .v_sync(b_vs), .frame_start(b_fs),
        .red(b_r), .green(b_g), .blue(b_b)
    );

    // C: small raster (60 x 28, 4-pixel dots, 8 x 4 grid), latency 2
    logic [2:0]  c_dot_x;
    logic [1:0]  c_dot_y;
    logic [7:0]  c_r, c_g, c_b;
    logic        c_draw, c_hs, c_vs, c_fs;
    logic [23:0] c_st [2];
    always @(posedge clk) begin
        c_st[0] <= store_word(8'(c_dot_x), 8'(c_dot_y));
        c_st[1] <= c_st[0];
    end
    dmd_video_gen #(
        .H_DRAW(40), .H_PORCH(4), .H_SYNC(8), .H_FRAME(60),
        .V_DRAW(20), .V_PORCH(1), .V_SYNC(3), .V_FRAME(28),
        .DOT(4), .GAP(1), .DOTS_X(8), .DOTS_Y(4), .FETCH_LAT(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .border_mode(border_mode),
        .dot_x(c_dot_x), .dot_y(c_dot_y),
        .dot_r(c_st[1][23:16]), .dot_g(c_st[1][15:8]), .dot_b(c_st[1][7:0]),
        .draw_area(c_draw), .h_sync(c_hs), .v_sync(c_vs), .frame_start(c_fs),
        .red(c_r), .green(c_g), .blue(c_b)
    );

    // D: same small raster, latency 4
    logic [2:0]  d_dot_x;
    logic [1:0]  d_dot_y;
    logic [7:0]  d_r, d_g, d_b;
    logic        d_draw, d_hs, d_vs, d_fs;
    logic [23:0] d_st [4];
    always @(posedge clk) begin
        d_st[0] <= store_word(8'(d_dot_x), 8'(d_dot_y));
        d_st[1] <= d_st[0];
        d_st[2] <= d_st[1];
        d_st[3] <= d_st[2];
    end
    dmd_video_gen #(
        .H_DRAW(40), .H_PORCH(4), .H_SYNC(8), .H_FRAME(60),
        .V_DRAW(20), .V_PORCH(1), .V_SYNC(3), .V_FRAME(28),
        .DOT(4), .GAP(1), .DOTS_X(8), .DOTS_Y(4), .FETCH_LAT(4)
    ) u_d (
        .clk(clk), .rst_n(rst_n), .border_mode(border_mode),
        .dot_x(d_dot_x), .dot_y(d_dot_y),
        .dot_r(d_st[3][23:16]), .dot_g(d_st[3][15:8]), .dot_b(d_st[3][7:0]),
        .draw_area(d_draw), .h_sync(d_hs), .v_sync(d_vs), .frame_start(d_fs),
        .red(d_r), .green(d_g), .blue(d_b)
    );

    // Advance to #1 after the target-th clock edge since reset release
    task automatic goto_cyc(input int target);
        if (cyc > target) begin
            checks_total++;
            $display("FAIL schedule: at cycle %0d, required <= %0d", cyc, target);
        end else begin
            while (cyc < target) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if ({a_draw, a_hs, a_vs, a_fs, c_draw, c_fs, d_draw, d_fs} !== 8'h00)
            $display("FAIL reset_strobes: got %b required 00000000",
                     {a_draw, a_hs, a_vs, a_fs, c_draw, c_fs, d_draw, d_fs});
        else checks_passed++;
        checks_total++;
        if ({a_r, a_g, a_b} !== 24'h0)
            $display("FAIL reset_colour: got %h required 000000", {a_r, a_g, a_b});
        else checks_passed++;
        checks_total++;
        if ({a_dot_x, a_dot_y} !== 13'h0)
            $display("FAIL reset_addr: got %h required 0000", {a_dot_x, a_dot_y});
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame_start;
        goto_cyc(2);
        checks_total++;
        if (a_fs !== 1'b0) $display("FAIL fs_early: got %b required 0", a_fs);
        else checks_passed++;
        goto_cyc(3);
        checks_total++;
        if ({a_fs, a_draw} !== 2'b11)
            $display("FAIL fs_first: got fs/draw %b required 11", {a_fs, a_draw});
        else checks_passed++;
    endtask

    task automatic test_hsync_default;
        goto_cyc(1282);
        checks_total++;
        if (a_draw !== 1'b1) $display("FAIL draw_last: got %b required 1", a_draw);
        else checks_passed++;
        goto_cyc(1283);
        checks_total++;
        if (a_draw !== 1'b0) $display("FAIL draw_end: got %b required 0", a_draw);
        else checks_passed++;
        goto_cyc(1314);
        checks_total++;
        if (a_hs !== 1'b0) $display("FAIL hs_before: got %b required 0", a_hs);
        else checks_passed++;
        goto_cyc(1315);
        checks_total++;
        if (a_hs !== 1'b1) $display("FAIL hs_rise: got %b required 1", a_hs);
        else checks_passed++;
        goto_cyc(1410);
        checks_total++;
        if (a_hs !== 1'b1) $display("FAIL hs_last: got %b required 1", a_hs);
        else checks_passed++;
        goto_cyc(1411);
        checks_total++;
        if (a_hs !== 1'b0) $display("FAIL hs_fall: got %b required 0", a_hs);
        else checks_passed++;
        goto_cyc(2754);
        checks_total++;
        if (a_hs !== 1'b0) $display("FAIL hs_line1_before: got %b required 0", a_hs);
        else checks_passed++;
        goto_cyc(2755);
        checks_total++;
        if (a_hs !== 1'b1) $display("FAIL hs_line_period: got %b required 1", a_hs);
        else checks_passed++;
    endtask

    task automatic test_narrow_grid;
        goto_cyc(8198);
        checks_total++;
        if ({b_r, b_g, b_b} !== 24'h6300AA)
            $display("FAIL narrow_last_dot: got %h required 6300aa", {b_r, b_g, b_b});
        else checks_passed++;
        goto_cyc(8206);
        checks_total++;
        if (b_dot_x !== 7'd99)
            $display("FAIL narrow_dot_x_sat: got %0d required 99", b_dot_x);
        else checks_passed++;
        goto_cyc(8208);
        checks_total++;
        if ({b_draw, b_r, b_g, b_b} !== 25'h1000000)
            $display("FAIL narrow_oob: got draw %b colour %h required 1 000000",
                     b_draw, {b_r, b_g, b_b});
        else checks_passed++;
    endtask

    task automatic test_dot_colour;
        goto_cyc(36013);
        checks_total++;
        if ({a_draw, a_r, a_g, a_b} !== 25'h1000000)
            $display("FAIL gap_pixel_10_25: got draw %b colour %h required 1 000000",
                     a_draw, {a_r, a_g, a_b});
        else checks_passed++;
        goto_cyc(36018);
        checks_total++;
        if ({a_r, a_g, a_b} !== 24'h0102AA)
            $display("FAIL pixel_15_25: got %h required 0102aa", {a_r, a_g, a_b});
        else checks_passed++;
    endtask

    task automatic test_reset_mid_line;
        goto_cyc(36020);
        checks_total++;
        if (a_r !== 8'h01) $display("FAIL pre_reset_red: got %h required 01", a_r);
        else checks_passed++;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if ({a_draw, a_r, a_g, a_b} !== 25'h0)
            $display("FAIL reset_async_drop: got draw %b colour %h required 0 000000",
                     a_draw, {a_r, a_g, a_b});
        else checks_passed++;
        repeat (7) @(posedge clk);
        #1;
        checks_total++;
        if ({a_draw, a_fs, a_dot_x, c_draw, c_r, d_draw, d_r} !== 28'h0)
            $display("FAIL reset_hold: got %h required 0000000",
                     {a_draw, a_fs, a_dot_x, c_draw, c_r, d_draw, d_r});
        else checks_passed++;
        @(negedge clk);
        rst_n = 1'b1;
        goto_cyc(2);
        checks_total++;
        if (c_fs !== 1'b0) $display("FAIL restart_fs_early: got %b required 0", c_fs);
        else checks_passed++;
        goto_cyc(3);
        checks_total++;
        if (c_fs !== 1'b1) $display("FAIL restart_fs: got %b required 1", c_fs);
        else checks_passed++;
        goto_cyc(4);
        checks_total++;
        if ({d_fs, d_draw} !== 2'b00)
            $display("FAIL lat4_fs_early: got fs/draw %b required 00", {d_fs, d_draw});
        else checks_passed++;
        goto_cyc(5);
        checks_total++;
        if ({d_fs, d_draw} !== 2'b11)
            $display("FAIL lat4_fs_draw: got fs/draw %b required 11", {d_fs, d_draw});
        else checks_passed++;
    endtask

    task automatic test_sync_small;
        goto_cyc(47);
        checks_total++;
        if (c_hs !== 1'b1) $display("FAIL small_hs_rise: got %b required 1", c_hs);
        else checks_passed++;
        goto_cyc(48);
        checks_total++;
        if (d_hs !== 1'b0) $display("FAIL lat4_hs_before: got %b required 0", d_hs);
        else checks_passed++;
        goto_cyc(49);
        checks_total++;
        if (d_hs !== 1'b1) $display("FAIL lat4_hs_rise: got %b required 1", d_hs);
        else checks_passed++;
    endtask

    task automatic test_oob_small;
        goto_cyc(338);
        checks_total++;
        if (c_dot_x !== 3'd7) $display("FAIL small_dot_x_sat: got %0d required 7", c_dot_x);
        else checks_passed++;
        goto_cyc(340);
        checks_total++;
        if ({c_draw, c_r, c_g, c_b} !== 25'h1000000)
            $display("FAIL small_oob: got draw %b colour %h required 1 000000",
                     c_draw, {c_r, c_g, c_b});
        else checks_passed++;
    endtask

    task automatic test_border_change;
        goto_cyc(600);
        border_mode = 2'd0;
        goto_cyc(787);
        checks_total++;
        if ({c_draw, c_r, c_g, c_b} !== 25'h1000000)
            $display("FAIL old_frame_gap: got draw %b colour %h required 1 000000",
                     c_draw, {c_r, c_g, c_b});
        else checks_passed++;
        goto_cyc(788);
        checks_total++;
        if ({c_r, c_g, c_b} !== 24'h0103AA)
            $display("FAIL old_frame_interior: got %h required 0103aa", {c_r, c_g, c_b});
        else checks_passed++;
        goto_cyc(1683);
        checks_total++;
        if ({c_fs, c_r, c_g, c_b} !== 25'h10000AA)
            $display("FAIL new_mode_first_pixel: got fs %b colour %h required 1 0000aa",
                     c_fs, {c_r, c_g, c_b});
        else checks_passed++;
        goto_cyc(2020);
        checks_total++;
        if ({c_r, c_g, c_b} !== 24'h0)
            $display("FAIL new_mode_oob: got %h required 000000", {c_r, c_g, c_b});
        else checks_passed++;
        goto_cyc(2467);
        checks_total++;
        if ({c_r, c_g, c_b} !== 24'h0103AA)
            $display("FAIL new_mode_gap: got %h required 0103aa", {c_r, c_g, c_b});
        else checks_passed++;
    endtask

    task automatic test_vsync_small;
        goto_cyc(2706);
        checks_total++;
        if (c_dot_y !== 2'd3) $display("FAIL small_dot_y_sat: got %0d required 3", c_dot_y);
        else checks_passed++;
        goto_cyc(2942);
        checks_total++;
        if (c_vs !== 1'b0) $display("FAIL vs_before: got %b required 0", c_vs);
        else checks_passed++;
        goto_cyc(2943);
        checks_total++;
        if (c_vs !== 1'b1) $display("FAIL vs_rise: got %b required 1", c_vs);
        else checks_passed++;
        goto_cyc(3122);
        checks_total++;
        if (c_vs !== 1'b1) $display("FAIL vs_last: got %b required 1", c_vs);
        else checks_passed++;
        goto_cyc(3123);
        checks_total++;
        if (c_vs !== 1'b0) $display("FAIL vs_fall: got %b required 0", c_vs);
        else checks_passed++;
    endtask

    task automatic test_dim_gap;
        goto_cyc(3200);
        border_mode = 2'd2;
        store_const = 1'b1;
        goto_cyc(3700);
        checks_total++;
        if ({c_r, c_g, c_b} !== 24'h0)
            $display("FAIL dim_oob: got %h required 000000", {c_r, c_g, c_b});
        else checks_passed++;
        goto_cyc(4147);
        checks_total++;
        if ({c_r, c_g, c_b} !== 24'h3F3F3F)
            $display("FAIL dim_gap: got %h required 3f3f3f", {c_r, c_g, c_b});
        else checks_passed++;
        goto_cyc(4148);
        checks_total++;
        if ({c_r, c_g, c_b} !== 24'hFFFFFF)
            $display("FAIL dim_interior: got %h required ffffff", {c_r, c_g, c_b});
        else checks_passed++;
        goto_cyc(4149);
        checks_total++;
        if ({d_r, d_g, d_b} !== 24'h3F3F3F)
            $display("FAIL lat4_dim_gap: got %h required 3f3f3f", {d_r, d_g, d_b});
        else checks_passed++;
        goto_cyc(4150);
        checks_total++;
        if ({d_r, d_g, d_b} !== 24'hFFFFFF)
            $display("FAIL lat4_dim_interior: got %h required ffffff", {d_r, d_g, d_b});
        else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_hsync_default();
        test_narrow_grid();
        test_dot_colour();
        test_reset_mid_line();
        test_sync_small();
        test_oob_small();
        test_border_change();
        test_vsync_small();
        test_dim_gap();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_dmd_video_gen
`default_nettype wire
